kyber_poly_reorder_buf: RTL
===========================

KYBER_POLY_REORDER_BUF -- requirements
Module: kyber_poly_reorder_buf

Interface
REQ-001 SHALL have parameter LANES, default 8, coefficients per bus word (legal: 2, 4, 8, 16).
REQ-002 SHALL have parameter COEF_W, default 16, bits per coefficient lane.
REQ-003 SHALL have parameter POLYS, default 1, polynomials per frame (legal: 1..4); WORDS = 256/LANES per polynomial.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  frame start request, sampled only in IDLE.
REQ-007 SHALL have port mode  input  1  output order, latched on accepted start: 0 natural, 1 bit-reversed word index.
REQ-008 SHALL have ports valid_in (input, 1), data_in (input, LANES*COEF_W) and ready_in (output, 1): input word handshake.
REQ-009 SHALL have ports valid_out (output, 1), data_out (output, LANES*COEF_W) and ready_out (input, 1): output word handshake with backpressure.
REQ-010 SHALL have port done  output  1  single-cycle frame-complete pulse.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, LOAD, DRAIN: IDLE->LOAD on start; LOAD->DRAIN after POLYS*WORDS accepted words; DRAIN->IDLE after the last output handshake.
REQ-013 SHALL hold ready_in high throughout LOAD and low in every other state; a word is accepted only when valid_in && ready_in.
REQ-014 SHALL store accepted word n (0-based) at buffer address n; lane j occupies bits [j*COEF_W +: COEF_W].
REQ-015 SHALL ignore valid_in outside LOAD and ignore start outside IDLE.
REQ-016 SHALL emit output word k at address p*WORDS + w, where p = k/WORDS and w = k%WORDS in mode 0, or w = bit-reverse of (k%WORDS) over log2(WORDS) bits in mode 1; lane order within a word is never changed.
REQ-017 SHALL raise valid_out exactly 2 cycles after the cycle in which the final input word is accepted.
REQ-018 SHALL keep data_out and valid_out stable while valid_out && !ready_out; advance only on valid_out && ready_out.
REQ-019 SHALL sustain one output word per cycle while ready_out is held high.
REQ-020 SHALL pulse done for exactly one cycle, in the cycle after the last output handshake, with valid_out low and the state IDLE in that cycle.
REQ-021 SHALL accept a start asserted in the same cycle as done only from the following cycle (start is honoured in IDLE only).

Reset
REQ-022 SHALL on reset drive ready_in=0, valid_out=0, data_out=0, done=0, busy=0, state IDLE, and clear all counters.
REQ-023 SHALL abort any LOAD or DRAIN in progress when reset asserts; buffer contents need not be cleared, and the next frame SHALL require a new start.

Configuration
REQ-024 SHALL, with KYBER_REDUCE_EN defined, reduce each input lane on write by one conditional subtraction of q=3329 (valid for inputs below 6658).
REQ-025 SHALL, without KYBER_REDUCE_EN, store lanes verbatim, with identical timing in both builds.

Structure
REQ-026 SHALL take KYBER_N=256, KYBER_Q=3329, the state enum and a bit-reverse function from shared package kyber_pkg.
REQ-027 SHALL instantiate sub-module kyber_poly_ram: simple dual-port memory, depth POLYS*WORDS, width LANES*COEF_W, synchronous 1-cycle read.

Verification
REQ-028 SHALL test LANES=8, POLYS=1, mode=0 with lane j of word i = 8i+j: 32 output words equal to input in order; done pulses 1 cycle after the 32nd output handshake.
REQ-029 SHALL test the same data with mode=1: output word 1 equals input word 16 (lanes 128..135), and output word 31 equals input word 31.
REQ-030 SHALL test ready_out toggling 1,0,1,0 during DRAIN: data_out held through each stall; exactly 32 handshakes, no duplicate or lost words.
REQ-031 SHALL test LANES=16, POLYS=3, mode=1 (48 words): output word 17 equals input word 24, and output word 32 equals input word 32.
REQ-032 SHALL test reset after 10 accepted words: all outputs 0 and busy=0 the next cycle; a fresh start then loads and drains a full 32-word frame correctly.
REQ-033 SHALL test with KYBER_REDUCE_EN defined: lanes 3329->0, 6657->3328, 3328->3328; without the macro all three are stored unchanged.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, reorder-buffer FSM states and a bit-reverse helper.
package kyber_pkg;

  localparam int KYBER_N = 256;
  localparam int KYBER_Q = 3329;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Reverse the low nbits of v; bits at and above nbits come back zero.
  function automatic logic [7:0] bit_reverse(input logic [7:0] v, input int nbits);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) r[i] = v[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/kyber_poly_ram.sv
// Simple dual-port word memory with a registered, enable-held read port.
module kyber_poly_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata only changes on re, so it doubles as the stalled output holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/kyber_poly_reorder_buf.sv
// Frame buffer: loads POLYS*WORDS words, then drains them in natural or bit-reversed word order.
// Optional build macro KYBER_REDUCE_EN: one conditional subtraction of q per lane on write.
module kyber_poly_reorder_buf
  import kyber_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int COEF_W = 16,
  parameter int POLYS  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic                    valid_in,
  input  logic [LANES*COEF_W-1:0] data_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [LANES*COEF_W-1:0] data_out,
  input  logic                    ready_out,
  output logic                    done,
  output logic                    busy
);

  localparam int WORDS = KYBER_N / LANES;
  localparam int TOTAL = POLYS * WORDS;
  localparam int AW    = $clog2(TOTAL);
  localparam int WB    = $clog2(WORDS);
  localparam int CW    = AW + 1;
  localparam int DW    = LANES * COEF_W;

  state_t          state_q, state_d;
  logic            mode_q;
  logic [CW-1:0]   wr_cnt, rd_cnt, out_cnt;
  logic            valid_q, done_q;
  logic            accept, hs, rd_en, last_in, last_out;
  logic [AW-1:0]   rd_addr;
  logic [7:0]      rev_w;
  logic [DW-1:0]   wr_data;

  // Handshakes: a word moves on a rising edge where valid && ready; the
  // producer holds valid and data steady until that edge.
  assign ready_in = (state_q == ST_LOAD);
  assign accept   = valid_in && ready_in;
  assign hs       = valid_q && ready_out;
  assign rd_en    = (state_q == ST_DRAIN) && (rd_cnt != CW'(TOTAL)) && (!valid_q || ready_out);
  assign last_in  = accept && (wr_cnt == CW'(TOTAL - 1));
  assign last_out = hs && (out_cnt == CW'(TOTAL - 1));

  // Polynomial index stays in the upper bits; only the in-polynomial word index is permuted.
  assign rev_w = bit_reverse(8'(rd_cnt[WB-1:0]), WB);
  always_comb begin
    rd_addr = rd_cnt[AW-1:0];
    if (mode_q) rd_addr[WB-1:0] = rev_w[WB-1:0];
  end

  always_comb begin
    wr_data = data_in;
`ifdef KYBER_REDUCE_EN
    for (int j = 0; j < LANES; j++) begin
      if (data_in[j*COEF_W +: COEF_W] >= COEF_W'(KYBER_Q))
        wr_data[j*COEF_W +: COEF_W] = data_in[j*COEF_W +: COEF_W] - COEF_W'(KYBER_Q);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)    state_d = ST_LOAD;
      ST_LOAD:  if (last_in)  state_d = ST_DRAIN;
      ST_DRAIN: if (last_out) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      out_cnt <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_out;
      if (state_q == ST_IDLE && start) begin
        mode_q  <= mode;
        wr_cnt  <= '0;
        rd_cnt  <= '0;
        out_cnt <= '0;
      end
      if (accept) wr_cnt  <= wr_cnt + 1'b1;
      if (rd_en)  rd_cnt  <= rd_cnt + 1'b1;
      if (hs)     out_cnt <= out_cnt + 1'b1;
      if (rd_en)   valid_q <= 1'b1;
      else if (hs) valid_q <= 1'b0;
    end
  end

  kyber_poly_ram #(
    .DEPTH(TOTAL),
    .AW   (AW),
    .DW   (DW)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (accept),
    .waddr(wr_cnt[AW-1:0]),
    .wdata(wr_data),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(data_out)
  );

  assign valid_out = valid_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
